// File: rtl/exec_controller.sv
// exec_controller: run/step/halt/breakpoint sequencing for the processor,
// issuing one-clk cpu_en advance strobes and counting executed instructions.
module exec_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             halt,
   input  logic [7:0]       pc,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             bp_hit,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;
   state_t           state_q, state_d;
   logic             step_q, first_q, first_d, cpu_en_q, cpu_en_d, bp_hit_q, bp_hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_req, t, bp_match;
   assign step_req = step_btn & ~step_q;
   // A tick landing on the clk cpu_en is high is dropped so cpu_en never fires twice in a row.
   assign t        = tick & ~cpu_en_q;
   assign bp_match = bp_en && (pc == bp_addr) && !first_q;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         step_q   <= 1'b0;
         first_q  <= 1'b0;
         cpu_en_q <= 1'b0;
         bp_hit_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_btn;
         first_q  <= first_d;
         cpu_en_q <= cpu_en_d;
         bp_hit_q <= bp_hit_d;
         cnt_q    <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = run_sw ? RUN : step_req ? STEP : IDLE;
         RUN:     state_d = !run_sw ? IDLE : !t ? RUN : halt ? HALTED : bp_match ? IDLE : RUN;
         STEP:    state_d = !t ? STEP : halt ? HALTED : IDLE;
         HALTED:  state_d = HALTED;
      endcase
   end
   always_comb begin
      cpu_en_d = t && !halt && ((state_q == RUN && run_sw && !bp_match) || state_q == STEP);
      first_d  = (state_q == IDLE && run_sw) ? 1'b1 : (state_q == RUN && t) ? 1'b0 : first_q;
      bp_hit_d = (state_q == IDLE && (run_sw || step_req)) ? 1'b0 :
                 (state_q == RUN && run_sw && t && !halt && bp_match) ? 1'b1 : bp_hit_q;
      cnt_d    = (cpu_en_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end
   assign cpu_en      = cpu_en_q;
   assign state       = state_q;
   assign bp_hit      = bp_hit_q;
   assign instr_count = cnt_q;
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: table vectors, directed sequences and a random run
// against a behavioural model of exec_controller (CNT_W=4).
module tb_exec_controller;
   logic       clk, rst, tick, run_sw, step_btn, halt, bp_en;
   logic [7:0] pc, bp_addr;
   logic       cpu_en, bp_hit;
   logic [1:0] state;
   logic [3:0] instr_count;
   int         errors = 0, checks = 0;

   exec_controller #(.CNT_W(4)) dut (
      .clk(clk), .rst(rst), .tick(tick), .run_sw(run_sw), .step_btn(step_btn),
      .halt(halt), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_en(cpu_en),
      .state(state), .bp_hit(bp_hit), .instr_count(instr_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Behavioural model: mode 0 idle, 1 free-run, 2 waiting to step, 3 halted.
   int  m_mode = 0, m_cnt = 0;
   bit  m_prev = 0, m_first = 0, m_en = 0, m_bp = 0;

   task automatic model_step();
      bit req, tk, en;
      if (!rst) begin
         m_mode = 0; m_cnt = 0; m_prev = 0; m_first = 0; m_en = 0; m_bp = 0;
         return;
      end
      req = step_btn && !m_prev;
      tk  = tick && !m_en;
      en  = 0;
      if (m_mode == 0) begin
         if (run_sw) begin m_mode = 1; m_first = 1; m_bp = 0; end
         else if (req) begin m_mode = 2; m_bp = 0; end
      end else if (m_mode == 1) begin
         if (!run_sw) m_mode = 0;
         else if (tk) begin
            if (halt) m_mode = 3;
            else if (bp_en && pc == bp_addr && !m_first) begin m_mode = 0; m_bp = 1; end
            else en = 1;
            m_first = 0;
         end
      end else if (m_mode == 2 && tk) begin
         if (halt) m_mode = 3;
         else begin en = 1; m_mode = 0; end
      end
      if (en && m_cnt < 15) m_cnt++;
      m_en = en;
      m_prev = step_btn;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic clear_in();
      tick = 0; run_sw = 0; step_btn = 0; halt = 0; bp_en = 0; pc = 0; bp_addr = 0;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 0;
      cyc();
      rst = 1;
   endtask

   task automatic run_tick(input string name, input logic exp_en);
      tick = 1;
      cyc();
      chk(name, 16'(cpu_en), 16'(exp_en));
      tick = 0;
      cyc();
      chk({name, "_gap"}, 16'(cpu_en), 16'd0);
   endtask

   typedef struct {
      logic       rst, tick, run_sw, step_btn, halt, bp_en;
      logic [7:0] pc, bp_addr;
      logic [1:0] st;
      logic       en, bp;
      logic [3:0] cnt;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input logic r, tk, rs, sb, h, be, input logic [7:0] p, ba,
                               input logic [1:0] st, input logic en, bp, input logic [3:0] cnt);
      vec_t v;
      v.rst = r; v.tick = tk; v.run_sw = rs; v.step_btn = sb; v.halt = h; v.bp_en = be;
      v.pc = p; v.bp_addr = ba; v.st = st; v.en = en; v.bp = bp; v.cnt = cnt;
      return v;
   endfunction

   initial begin
      int pulses;
      clear_in();
      rst = 0;
      //               rst tk rs sb h be pc bpa  st en bp cnt
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 1, 0, 2));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2));
      tbl.push_back(mk(1, 0, 0, 1, 0, 1, 4, 4, 2'd2, 0, 0, 2));
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 4, 4, 2'd0, 1, 0, 3));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 0, 0, 3));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 2'd3, 0, 0, 3));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd3, 0, 0, 3));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; tick = tbl[i].tick; run_sw = tbl[i].run_sw;
         step_btn = tbl[i].step_btn; halt = tbl[i].halt; bp_en = tbl[i].bp_en;
         pc = tbl[i].pc; bp_addr = tbl[i].bp_addr;
         cyc();
         chk($sformatf("tbl%0d", i), {9'd0, state, cpu_en, bp_hit, instr_count},
             {9'd0, tbl[i].st, tbl[i].en, tbl[i].bp, tbl[i].cnt});
      end

      // free run
      do_reset();
      chk("rst_state", {9'd0, state, cpu_en, bp_hit, instr_count}, 16'd0);
      run_sw = 1;
      cyc();
      for (int i = 0; i < 5; i++) run_tick($sformatf("free%0d", i), 1);
      chk("free_cnt", 16'(instr_count), 16'd5);
      chk("free_state", 16'(state), 16'd1);

      // halt then locked
      do_reset();
      run_sw = 1;
      cyc();
      run_tick("halt_t1", 1);
      run_tick("halt_t2", 1);
      halt = 1;
      run_tick("halt_t3", 0);
      halt = 0;
      for (int i = 0; i < 8; i++) begin
         run_sw = i[0]; step_btn = i[1]; tick = 1;
         cyc();
         chk($sformatf("halted%0d", i), {14'd0, state} | {15'd0, cpu_en} << 8, 16'd3);
      end
      chk("halt_cnt", 16'(instr_count), 16'd2);
      rst = 0; tick = 0;
      cyc();
      rst = 1;
      chk("halt_rst", 16'(state), 16'd0);

      // breakpoint and resume
      do_reset();
      bp_en = 1; bp_addr = 8'h04; pc = 8'h02; run_sw = 1;
      cyc();
      run_tick("bp_pc2", 1);
      pc = 8'h03;
      run_tick("bp_pc3", 1);
      pc = 8'h04; tick = 1;
      cyc();
      chk("bp_hit_state", {13'd0, state, bp_hit}, {13'd0, 2'd0, 1'b1});
      chk("bp_hit_en", 16'(cpu_en), 16'd0);
      run_sw = 0; tick = 0;
      cyc();
      chk("bp_idle_hold", {13'd0, state, bp_hit}, {13'd0, 2'd0, 1'b1});
      run_sw = 1;
      cyc();
      chk("bp_resume", {13'd0, state, bp_hit}, {13'd0, 2'd1, 1'b0});
      run_tick("bp_first_exec", 1);
      tick = 1;
      cyc();
      chk("bp_rehit", {13'd0, state, bp_hit, cpu_en}, {13'd0, 2'd0, 1'b1, 1'b0});
      tick = 0;

      // single step with held button
      do_reset();
      step_btn = 1;
      cyc();
      chk("step_enter", 16'(state), 16'd2);
      pulses = 0;
      for (int i = 1; i < 10; i++) begin
         tick = (i % 3 == 0);
         cyc();
         pulses += cpu_en;
      end
      step_btn = 0; tick = 0;
      chk("step_pulses", 16'(pulses), 16'd1);
      chk("step_state", 16'(state), 16'd0);
      chk("step_cnt", 16'(instr_count), 16'd1);

      // reset priority
      do_reset();
      run_sw = 1;
      cyc();
      run_tick("rp_t1", 1);
      run_tick("rp_t2", 1);
      rst = 0; tick = 1;
      cyc();
      chk("rp_rst", {9'd0, state, cpu_en, bp_hit, instr_count}, 16'd0);
      rst = 1;
      cyc();
      chk("rp_first_clk", 16'(cpu_en), 16'd0);
      tick = 0;

      // saturation
      do_reset();
      run_sw = 1;
      cyc();
      for (int i = 0; i < 20; i++) begin
         tick = 1; cyc(); tick = 0; cyc();
      end
      chk("sat_cnt", 16'(instr_count), 16'd15);
      chk("sat_state", 16'(state), 16'd1);

      // random against model
      do_reset();
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) run_sw = ~run_sw;
         if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
         halt = ($urandom_range(0, 39) == 0);
         bp_en = 1'($urandom_range(0, 1));
         pc = 8'($urandom_range(0, 7));
         bp_addr = 8'($urandom_range(3, 5));
         cyc();
         chk($sformatf("rand%0d", i), {9'd0, state, cpu_en, bp_hit, instr_count},
             {9'd0, 2'(m_mode), m_en, m_bp, 4'(m_cnt)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
